fxp_seq_multiplier: RTL

FXP_SEQ_MULTIPLIER -- requirements
Module: fxp_seq_multiplier

---
 rtl/fxp_pkg.sv | 14 +
 rtl/fxp_saturate.sv | 52 +++++
 rtl/fxp_seq_multiplier.sv | 116 +++++++++++
 3 files changed

// File: rtl/fxp_pkg.sv
// Shared definitions for the sequential fixed-point multiplier:
// FSM state encoding and default operand geometry (Q16.16 in 32 bits).
package fxp_pkg;

    localparam int FXP_DEFAULT_WIDTH = 32;
    localparam int FXP_DEFAULT_FRAC  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fxp_state_t;

endpackage

// File: rtl/fxp_saturate.sv
// Combinational post-processing of the full signed product: optional
// rounding, arithmetic right shift by FRAC, and clamp to WIDTH bits.
// Build option: define FXP_MUL_ROUND_EN to round half toward +infinity
// before the shift; otherwise the shift truncates (floor).
module fxp_saturate
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_DEFAULT_WIDTH,
    parameter int FRAC  = FXP_DEFAULT_FRAC
) (
    input  logic signed [2*WIDTH-1:0] i_product,
    output logic        [WIDTH-1:0]   o_result,
    output logic                      o_ovf
);

    // One guard bit keeps the rounding add from ever wrapping.
    localparam int EW = 2 * WIDTH + 1;

    logic signed [EW-1:0] w_ext;
    logic signed [EW-1:0] w_rounded;
    logic signed [EW-1:0] w_scaled;
    logic signed [EW-1:0] w_max;
    logic signed [EW-1:0] w_min;

    assign w_ext = {i_product[2*WIDTH-1], i_product};

`ifdef FXP_MUL_ROUND_EN
    assign w_rounded = w_ext + (EW'(1) <<< (FRAC - 1));
`else
    assign w_rounded = w_ext;
`endif

    assign w_scaled = w_rounded >>> FRAC;

    // Largest positive and most negative WIDTH-bit values, sign-extended.
    assign w_max = {{(WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
    assign w_min = {{(WIDTH + 2){1'b1}}, {(WIDTH - 1){1'b0}}};

    // Clamp the scaled value into range and flag any clamping.
    always_comb begin
        o_result = w_scaled[WIDTH-1:0];
        o_ovf    = 1'b0;
        if (w_scaled > w_max) begin
            o_result = {1'b0, {(WIDTH - 1){1'b1}}};
            o_ovf    = 1'b1;
        end else if (w_scaled < w_min) begin
            o_result = {1'b1, {(WIDTH - 1){1'b0}}};
            o_ovf    = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_seq_multiplier.sv
// Sequential signed fixed-point multiplier, Q(WIDTH-FRAC).FRAC operands.
// Valid/ready handshake on both sides. Operand magnitudes are multiplied
// by shift-add, one multiplier bit per cycle for WIDTH cycles; one more
// cycle applies the sign and registers the saturated result, so out_valid
// rises WIDTH+1 edges after the accepting edge.
// Build option: FXP_MUL_ROUND_EN (see fxp_saturate) selects rounding;
// latency is the same either way.
module fxp_seq_multiplier
    import fxp_pkg::*;
#(
    parameter int WIDTH = FXP_DEFAULT_WIDTH,
    parameter int FRAC  = FXP_DEFAULT_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    // Counter must reach WIDTH itself: that value marks the finalize cycle.
    localparam int CW = $clog2(WIDTH + 1);

    fxp_state_t         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [WIDTH-1:0]   r_result;
    logic               r_ovf;

    logic                      w_accept;
    logic [WIDTH-1:0]          w_a_mag;
    logic [WIDTH-1:0]          w_b_mag;
    logic signed [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]          w_sat_result;
    logic                      w_sat_ovf;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign w_accept  = in_valid && in_ready;

    // Unsigned magnitudes: the most-negative value maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits, so it is handled exactly.
    assign w_a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Magnitude product is at most 2^(2*WIDTH-2), so negation cannot wrap;
    // a zero product stays zero whatever the sign flag says.
    assign w_product = r_neg ? -$signed(r_acc) : $signed(r_acc);

    fxp_saturate #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_saturate (
        .i_product (w_product),
        .o_result  (w_sat_result),
        .o_ovf     (w_sat_ovf)
    );

    // Handshake FSM with shift-add datapath; operands are only sampled in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == CW'(WIDTH)) begin
                        r_result <= w_sat_result;
                        r_ovf    <= w_sat_ovf;
                        r_state  <= DONE;
                    end else begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
